// File: rtl/alu4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu4_arbiter
// Description : Two-requester round-robin arbiter in front of a shared
//               combinational 4-bit ALU. A granted operation is held on the
//               ALU for SETTLE_CYCLES cycles, the result and carry are then
//               captured, and the response is held until the consumer takes it.
// Ports       : ck/rst              clock, synchronous active-high reset
//               req{0,1}_valid/ready handshake per requester
//               req{0,1}_op/_a/_b   opcode and operands per requester
//               alu_op/alu_a/alu_b  operands to the shared ALU (registered)
//               alu_y/alu_co        result and carry from the shared ALU
//               rsp_valid/ready     response handshake
//               rsp_id/rsp_y/rsp_co owner index, captured result and carry
//               busy                high whenever the FSM is not idle
// Parameters  : SETTLE_CYCLES       ALU settle time in cycles, legal 1..15
// Revision    : 1.0  initial release
// ============================================================================
module alu4_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic [1:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_y,
    input  logic       alu_co,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_y,
    output logic       rsp_co,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Counter is loaded with SETTLE_CYCLES-1 so the capture edge lands exactly
    // SETTLE_CYCLES edges after the accept edge.
    localparam logic [3:0] c_cnt_load = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;
    logic [3:0] r_cnt;
    logic [1:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [3:0] r_rsp_y;
    logic       r_rsp_co;

    logic       w_idle;
    logic       w_win;
    logic       w_accept;

    // Winner index: on a tie the requester not granted last wins; a lone
    // requester wins regardless of the pointer.
    assign w_idle     = (r_state == S_IDLE);
    assign w_win      = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_accept   = w_idle & (req0_valid | req1_valid);

    assign req0_ready = w_accept & ~w_win;
    assign req1_ready = w_accept &  w_win;

    assign alu_op     = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_y      = r_rsp_y;
    assign rsp_co     = r_rsp_co;
    assign busy       = ~w_idle;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)        w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == 4'd0)   w_state_nxt = S_RESP;
            S_RESP:   if (rsp_ready)       w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_op        <= 2'd0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= 4'd0;
            r_rsp_co    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_win ? req1_op : req0_op;
                        r_a      <= w_win ? req1_a  : req0_a;
                        r_b      <= w_win ? req1_b  : req0_b;
                        r_rsp_id <= w_win;
                        r_last   <= w_win;
                        r_cnt    <= c_cnt_load;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_y     <= alu_y;
                        r_rsp_co    <= alu_co;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu4_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4_arbiter
// Description : Self-checking bench for alu4_arbiter. A transaction-level
//               reference model predicts the grant winner, response timing,
//               result and owner of every operation. A second instance with a
//               longer settle time covers aborting an operation by reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu4_arbiter;

    localparam int S  = 2;
    localparam int S4 = 4;

    logic       ck = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_ready;

    logic       req0_ready, req1_ready;
    logic [1:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_y;
    logic       alu_co;
    logic       rsp_valid, rsp_id, rsp_co, busy;
    logic [3:0] rsp_y;

    logic       req0_ready_4, req1_ready_4;
    logic [1:0] alu_op_4;
    logic [3:0] alu_a_4, alu_b_4, alu_y_4;
    logic       alu_co_4;
    logic       rsp_valid_4, rsp_id_4, rsp_co_4, busy_4;
    logic [3:0] rsp_y_4;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    bit m_last  = 1'b1;

    always #5 ck = ~ck;

    // Shared combinational ALU seen by each instance.
    function automatic logic [4:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a ^ b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_co, alu_y}     = alu_f(alu_op, alu_a, alu_b);
    assign {alu_co_4, alu_y_4} = alu_f(alu_op_4, alu_a_4, alu_b_4);

    alu4_arbiter #(.SETTLE_CYCLES(S)) u_dut (
        .ck(ck), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_co(alu_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_co(rsp_co),
        .busy(busy)
    );

    alu4_arbiter #(.SETTLE_CYCLES(S4)) u_dut4 (
        .ck(ck), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready_4), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready_4), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op_4), .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_y(alu_y_4), .alu_co(alu_co_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_id(rsp_id_4), .rsp_y(rsp_y_4), .rsp_co(rsp_co_4),
        .busy(busy_4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete operation. Entered just after a falling edge with the
    // design idle; returns just after a falling edge with the design idle.
    task automatic do_op(input logic v0, input logic v1,
                         input logic [1:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [1:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                         input int hold, input bit jit);
        logic       w;
        logic [1:0] eop;
        logic [3:0] ea, eb, ey;
        logic       eco;
        int         sum;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready  = jit ? 1'($urandom) : 1'b0;
        #1;
        w = (v0 && v1) ? ~m_last : v1;
        chk("grant_ready0", {7'd0, req0_ready}, {7'd0, ~w});
        chk("grant_ready1", {7'd0, req1_ready}, {7'd0, w});
        chk("idle_busy", {7'd0, busy}, 8'd0);
        eop = w ? o1 : o0;
        ea  = w ? a1 : a0;
        eb  = w ? b1 : b0;
        sum = int'(ea) + int'(eb);
        case (eop)
            2'd0:    begin ey = 4'(sum % 16); eco = (sum > 15); end
            2'd1:    begin ey = ea ^ eb; eco = 1'b0; end
            2'd2:    begin ey = ea & eb; eco = 1'b0; end
            default: begin ey = ea | eb; eco = 1'b0; end
        endcase
        m_last = w;
        @(posedge ck);
        for (int i = 0; i < S; i++) begin
            @(negedge ck);
            chk("settle_valid", {7'd0, rsp_valid}, 8'd0);
            chk("settle_busy", {7'd0, busy}, 8'd1);
            chk("settle_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
            chk("settle_alu", {alu_op, alu_a, 2'b00} ^ {6'd0, 2'b00} , {eop, ea, 2'b00});
            chk("settle_alu_b", {4'd0, alu_b}, {4'd0, eb});
            if (jit) begin
                req0_valid = 1'($urandom);
                req1_valid = 1'($urandom);
                rsp_ready  = 1'($urandom);
            end
        end
        @(negedge ck);
        chk("rsp_valid", {7'd0, rsp_valid}, 8'd1);
        chk("rsp_y", {4'd0, rsp_y}, {4'd0, ey});
        chk("rsp_co", {7'd0, rsp_co}, {7'd0, eco});
        chk("rsp_id", {7'd0, rsp_id}, {7'd0, w});
        chk("rsp_busy", {7'd0, busy}, 8'd1);
        chk("rsp_ready_out", {6'd0, req1_ready, req0_ready}, 8'd0);
        rsp_ready = (hold == 0);
        for (int k = 1; k < hold; k++) begin
            @(negedge ck);
            chk("hold_valid", {7'd0, rsp_valid}, 8'd1);
            chk("hold_y", {4'd0, rsp_y}, {4'd0, ey});
            chk("hold_id_co", {6'd0, rsp_id, rsp_co}, {6'd0, w, eco});
            chk("hold_ready_out", {6'd0, req1_ready, req0_ready}, 8'd0);
            if (jit) begin
                req0_valid = 1'($urandom);
                req1_valid = 1'($urandom);
            end
        end
        rsp_ready = 1'b1;
        @(negedge ck);
        chk("release_valid", {7'd0, rsp_valid}, 8'd0);
        chk("release_busy", {7'd0, busy}, 8'd0);
        chk("release_alu_held", {alu_op, alu_a, 2'b00}, {eop, ea, 2'b00});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_op = 2'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp_ready = 1'b0;

        // Reset with no requests.
        repeat (2) @(posedge ck);
        @(negedge ck);
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_busy", {6'd0, busy_4, busy}, 8'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 8'd0);
        chk("rst_alu_op", {6'd0, alu_op}, 8'd0);
        chk("rst_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        chk("rst_rsp", {2'd0, rsp_id, rsp_co, rsp_y}, 8'd0);
        rst = 1'b0;
        m_last = 1'b1;

        // ADD 9+8 from requester 0: Y=1, CO=1.
        do_op(1'b1, 1'b0, 2'd0, 4'd9, 4'd8, 2'd0, 4'd0, 4'd0, 0, 1'b0);

        // Both requesters valid: alternate grants, XOR 5^3=6, AND 12&10=8.
        for (int n = 0; n < 4; n++)
            do_op(1'b1, 1'b1, 2'd1, 4'd5, 4'd3, 2'd2, 4'd12, 4'd10, 0, 1'b0);

        // Response back-pressured for 5 cycles.
        do_op(1'b1, 1'b0, 2'd0, 4'd15, 4'd15, 2'd0, 4'd0, 4'd0, 5, 1'b0);

        // Only requester 1 valid twice: OR 4|1=5.
        do_op(1'b0, 1'b1, 2'd0, 4'd0, 4'd0, 2'd3, 4'd4, 4'd1, 0, 1'b0);
        do_op(1'b0, 1'b1, 2'd0, 4'd0, 4'd0, 2'd3, 4'd4, 4'd1, 0, 1'b0);

        // Randomized operations with input jitter while busy.
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            do_op(v[0], v[1], 2'($urandom), 4'($urandom), 4'($urandom),
                  2'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 3)), 1'b1);
        end

        // Abort during settle on the longer-settle instance.
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge ck);
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 4'd3; req0_b = 4'd4;
        #1;
        chk("abort_accept_ready", {7'd0, req0_ready_4}, 8'd1);
        @(negedge ck);
        req0_valid = 1'b0;
        chk("abort_busy_settle", {7'd0, busy_4}, 8'd1);
        @(negedge ck);
        rst = 1'b1;
        @(negedge ck);
        rst = 1'b0;
        chk("abort_busy", {7'd0, busy_4}, 8'd0);
        chk("abort_rsp_valid", {7'd0, rsp_valid_4}, 8'd0);
        chk("abort_alu", {alu_a_4, alu_b_4}, 8'd0);
        for (int n = 0; n < 8; n++) begin
            @(negedge ck);
            chk("abort_no_rsp", {7'd0, rsp_valid_4}, 8'd0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("abort_last_ready", {6'd0, req1_ready_4, req0_ready_4}, 8'd1);
        @(negedge ck);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu4_arbiter.md
ALU4_ARBITER -- requirements
Module: alu4_arbiter

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles the operands are held on the shared ALU before the result is captured; legal range 1..15.
REQ-002 CK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 REQ0_VALID / REQ1_VALID  input  1  requester n presents an operation.
REQ-005 REQ0_READY / REQ1_READY  output  1  requester n operation accepted this cycle when VALID & READY.
REQ-006 REQ0_OP / REQ1_OP  input  2  opcode: 00 ADD, 01 XOR, 10 AND, 11 OR.
REQ-007 REQ0_A, REQ0_B / REQ1_A, REQ1_B  input  4  operands.
REQ-008 ALU_OP  output  2  opcode to the shared combinational 4-bit ALU.
REQ-009 ALU_A, ALU_B  output  4  operands to the shared ALU.
REQ-010 ALU_Y  input  4  ALU result.
REQ-011 ALU_CO  input  1  ALU carry-out; meaningful for ADD only, captured for all ops.
REQ-012 RSP_VALID  output  1  response available.
REQ-013 RSP_READY  input  1  consumer takes response when RSP_VALID & RSP_READY.
REQ-014 RSP_ID  output  1  index of the requester that owns the response.
REQ-015 RSP_Y  output  4; RSP_CO  output  1  captured result and carry.
REQ-016 BUSY  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, SETTLE, RESP; state is fully registered.
REQ-018 IDLE: winner = the valid requester; when both are valid, the requester not granted last (round-robin pointer LAST) wins; only the winner sees READY=1, the other sees 0.
REQ-019 READY outputs are 0 in SETTLE and RESP.
REQ-020 On accept (edge with VALID & READY): OP/A/B latched into operand registers, winner index latched as RSP_ID and into LAST, counter loaded with SETTLE_CYCLES-1, state -> SETTLE.
REQ-021 ALU_OP/ALU_A/ALU_B are driven only from operand registers; values are held unchanged in IDLE and RESP (no toggling without a new accept).
REQ-022 SETTLE: counter decrements each edge; on the edge where counter = 0, ALU_Y/ALU_CO are captured into RSP_Y/RSP_CO, RSP_VALID is set, and state -> RESP.
REQ-023 Latency: RSP_VALID rises exactly SETTLE_CYCLES edges after the accept edge.
REQ-024 RESP: RSP_VALID, RSP_ID, RSP_Y, RSP_CO are held stable until RSP_READY=1; on that edge RSP_VALID clears and state -> IDLE.
REQ-025 RSP_READY already high on entering RESP: RESP lasts exactly one cycle.
REQ-026 Throughput: at most one accept per SETTLE_CYCLES+2 cycles; the IDLE cycle is mandatory between responses.
REQ-027 A requester deasserting VALID while READY=0 is legal; no transfer, no state change.
REQ-028 RSP_READY is ignored outside RESP.
REQ-029 Single requester valid: it is granted regardless of LAST (no wasted cycle).

Reset
REQ-030 RST=1 at a rising edge forces state IDLE, LAST=1 (REQ0 wins first tie), counter=0, operand registers=0, RSP_VALID=0, RSP_ID=0, RSP_Y=0, RSP_CO=0.
REQ-031 Combinational outputs after reset: REQ0_READY/REQ1_READY follow REQ-018, BUSY=0, ALU_OP/ALU_A/ALU_B=0.
REQ-032 RST in SETTLE or RESP aborts the operation; the pending response is discarded and never presented.

Verification (bench ALU model: ADD Y=(A+B) mod 16, CO=carry; XOR/AND/OR bitwise, CO=0)
REQ-033 Assert RST 2 cycles, no requests -> RSP_VALID=0, BUSY=0, ALU_A=ALU_B=0, both READY=0.
REQ-034 SETTLE_CYCLES=2, REQ0 ADD A=9 B=8, RSP_READY=1 -> REQ0_READY=1 in cycle 0; RSP_VALID=1 two edges later with RSP_Y=1, RSP_CO=1, RSP_ID=0; BUSY=1 for 3 cycles.
REQ-035 Both VALID held high, REQ0 XOR 5^3, REQ1 AND 12&10 -> grant order 0,1,0,1; RSP_Y alternates 6, 8; RSP_IDs 0,1,0,1.
REQ-036 Response with RSP_READY low for 5 cycles -> RSP_VALID/RSP_Y/RSP_ID stable for 5 cycles, both READY=0; released 1 cycle after RSP_READY rises.
REQ-037 RST pulsed during SETTLE (SETTLE_CYCLES=4) -> next cycle IDLE, RSP_VALID never asserts for that request; LAST=1.
REQ-038 Only REQ1 valid on two consecutive operations (OR 4|1) -> both granted to REQ1, RSP_Y=5, RSP_CO=0.
